// File: rtl/rf_pkg.sv
// Shared types for the 16x16 register file and its read-side agent.
// The entry struct is the unit stored in the read-port response FIFO.
package rf_pkg;

   localparam int NUM_REGS = 16;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   typedef logic [ADDR_W-1:0] rf_idx_t;
   typedef logic [DATA_W-1:0] rf_word_t;

   typedef struct packed {
      rf_idx_t  src1;
      rf_idx_t  src2;
      rf_word_t data1;
      rf_word_t data2;
   } rd_entry_t;

endpackage

// File: rtl/rf_operand_sel.sv
// Operand source select: zero register, then snooped write, then current data.
// Used both for capture from the file and for refreshing buffered operands.
module rf_operand_sel #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 4,
   parameter bit ZERO_REG_EN = 1'b0
) (
   input  logic [ADDR_W-1:0] src,
   input  logic [DATA_W-1:0] cur_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] sel_data
);

   logic is_zero;
   logic wr_hit;

   assign is_zero = ZERO_REG_EN && (src == '0);
   assign wr_hit  = wr_en && (wr_addr == src) && !is_zero;

   always_comb begin
      if (is_zero)     sel_data = '0;
      else if (wr_hit) sel_data = wr_data;
      else             sel_data = cur_data;
   end

endmodule

// File: rtl/rf_read_port.sv
// Read-side agent for the register file: issues read addresses, captures both
// operands into a response FIFO and keeps buffered operands coherent with writes.
module rf_read_port #(
   parameter int DATA_W      = rf_pkg::DATA_W,
   parameter int ADDR_W      = rf_pkg::ADDR_W,
   parameter int DEPTH       = 2,
   parameter bit ZERO_REG_EN = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_src1,
   input  logic [ADDR_W-1:0] req_src2,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   input  logic [DATA_W-1:0] rf_data1,
   input  logic [DATA_W-1:0] rf_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2
);

   import rf_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   rd_entry_t         mem_q [DEPTH];
   rd_entry_t         mem_d [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;
   logic [DATA_W-1:0] cap1, cap2;
   logic [DATA_W-1:0] ref1 [DEPTH];
   logic [DATA_W-1:0] ref2 [DEPTH];

   // Slot idx holds a live entry when its distance from the head is below the count.
   function automatic logic is_live(input logic [PTR_W-1:0] idx,
                                    input logic [PTR_W-1:0] head,
                                    input logic [CNT_W-1:0] cnt);
      logic [PTR_W-1:0] offs;
      offs = idx - head;
      return CNT_W'(offs) < cnt;
   endfunction

   assign rf_addr1  = req_src1;
   assign rf_addr2  = req_src2;
   assign req_ready = (count_q != CNT_W'(DEPTH));
   assign rsp_valid = (count_q != '0);
   assign push      = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   rf_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_cap1 (
      .src(req_src1), .cur_data(rf_data1), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .sel_data(cap1)
   );

   rf_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_cap2 (
      .src(req_src2), .cur_data(rf_data2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .sel_data(cap2)
   );

   // Refresh candidates: each stored operand re-selected against the current write.
   for (genvar g = 0; g < DEPTH; g++) begin : g_refresh
      rf_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_ref1 (
         .src(mem_q[g].src1), .cur_data(mem_q[g].data1), .wr_en(wr_en),
         .wr_addr(wr_addr), .wr_data(wr_data), .sel_data(ref1[g])
      );
      rf_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_ref2 (
         .src(mem_q[g].src2), .cur_data(mem_q[g].data2), .wr_en(wr_en),
         .wr_addr(wr_addr), .wr_data(wr_data), .sel_data(ref2[g])
      );
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (is_live(PTR_W'(i), rd_ptr_q, count_q) && !(pop && PTR_W'(i) == rd_ptr_q)) begin
            mem_d[i].data1 = ref1[i];
            mem_d[i].data2 = ref2[i];
         end
         // The write slot is never live while there is room, so capture cannot collide with refresh.
         if (push && PTR_W'(i) == wr_ptr_q) begin
            mem_d[i].src1  = req_src1;
            mem_d[i].src2  = req_src2;
            mem_d[i].data1 = cap1;
            mem_d[i].data2 = cap2;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         rsp_data1 <= '0;
         rsp_data2 <= '0;
         // NOTE: the entry storage is reset too, so no stale operand survives a reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
         // When the FIFO drains the outputs keep the last popped operands.
         if (count_d != '0) begin
            rsp_data1 <= mem_d[rd_ptr_d].data1;
            rsp_data2 <= mem_d[rd_ptr_d].data2;
         end
      end
   end

endmodule

// File: tb/tb_rf_read_port.sv
// Bench for rf_read_port: two instances (zero register off / on) share stimulus and are
// compared every cycle against a register-file model plus directed literal expectations.
module tb_rf_read_port;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic [AW-1:0] req_src1, req_src2;
   logic [DW-1:0] rf_data1, rf_data2;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rsp_ready;

   logic          req_ready_n, req_ready_z;
   logic [AW-1:0] rf_addr1_n, rf_addr2_n, rf_addr1_z, rf_addr2_z;
   logic          rsp_valid_n, rsp_valid_z;
   logic [DW-1:0] rsp_data1_n, rsp_data2_n, rsp_data1_z, rsp_data2_z;

   logic [DW-1:0] regs [16];

   typedef struct {
      logic [AW-1:0] s1;
      logic [AW-1:0] s2;
   } req_t;
   req_t mq[$];

   int checks   = 0;
   int failures = 0;

   assign rf_data1 = regs[req_src1];
   assign rf_data2 = regs[req_src2];

   rf_read_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG_EN(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_n),
      .req_src1(req_src1), .req_src2(req_src2), .rf_addr1(rf_addr1_n), .rf_addr2(rf_addr2_n),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1_n), .rsp_data2(rsp_data2_n)
   );

   rf_read_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG_EN(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_z),
      .req_src1(req_src1), .req_src2(req_src2), .rf_addr1(rf_addr1_z), .rf_addr2(rf_addr2_z),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1_z), .rsp_data2(rsp_data2_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural value of a register as seen by a port with or without the zero register.
   function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] src, input bit zero_en);
      if (zero_en && src == '0) return '0;
      return regs[src];
   endfunction

   // Model: a queue of pending source pairs; buffered operands always equal the current file contents.
   initial begin
      bit m_push, m_pop;
      for (int i = 0; i < 16; i++) regs[i] <= 16'(i * 16'h0011);
      regs[7] <= 16'h1111;
      regs[9] <= 16'h0009;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
         end else begin
            m_pop  = (mq.size() != 0) && rsp_ready;
            m_push = req_valid && (mq.size() != DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{req_src1, req_src2});
            if (wr_en) regs[wr_addr] <= wr_data;
         end
      end
   end

   task automatic compare_dut(input string tag, input bit zero_en, input logic ready,
                              input logic valid, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      check({tag, ".req_ready"}, 32'(ready), 32'(mq.size() != DEPTH));
      check({tag, ".rsp_valid"}, 32'(valid), 32'(mq.size() != 0));
      check({tag, ".rf_addr1"}, 32'(a1), 32'(req_src1));
      check({tag, ".rf_addr2"}, 32'(a2), 32'(req_src2));
      if (mq.size() != 0) begin
         check({tag, ".rsp_data1"}, 32'(d1), 32'(arch_val(mq[0].s1, zero_en)));
         check({tag, ".rsp_data2"}, 32'(d2), 32'(arch_val(mq[0].s2, zero_en)));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            compare_dut("dut_n", 1'b0, req_ready_n, rsp_valid_n, rsp_data1_n, rsp_data2_n,
                        rf_addr1_n, rf_addr2_n);
            compare_dut("dut_z", 1'b1, req_ready_z, rsp_valid_z, rsp_data1_z, rsp_data2_z,
                        rf_addr1_z, rf_addr2_z);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_state_checks(input string when);
      check({when, ".n.rsp_valid"}, 32'(rsp_valid_n), 32'd0);
      check({when, ".n.req_ready"}, 32'(req_ready_n), 32'd1);
      check({when, ".z.rsp_valid"}, 32'(rsp_valid_z), 32'd0);
      check({when, ".z.req_ready"}, 32'(req_ready_z), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_src1  = 4'd3;
      req_src2  = 4'd5;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      rsp_ready = 1'b0;
      repeat (3) step();

      // Reset holds the port idle even with a request offered.
      idle_state_checks("reset");
      check("reset.n.rsp_data1", 32'(rsp_data1_n), 32'h0);
      check("reset.n.rsp_data2", 32'(rsp_data2_n), 32'h0);
      check("reset.z.rsp_data1", 32'(rsp_data1_z), 32'h0);
      check("reset.z.rsp_data2", 32'(rsp_data2_z), 32'h0);

      req_valid = 1'b0;
      rst_n     = 1'b1;
      step();

      // First push: visible right after the accepting edge.
      req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd5;
      step();
      req_valid = 1'b0;
      check("first.rsp_valid", 32'(rsp_valid_n), 32'd1);
      check("first.rsp_data1", 32'(rsp_data1_n), 32'h0033);
      check("first.rsp_data2", 32'(rsp_data2_n), 32'h0055);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Write bypass at capture.
      req_valid = 1'b1; req_src1 = 4'd7; req_src2 = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
      step();
      req_valid = 1'b0; wr_en = 1'b0;
      check("bypass.rsp_data1", 32'(rsp_data1_n), 32'hBEEF);
      check("bypass.rsp_data2", 32'(rsp_data2_n), 32'h0022);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Refresh of a buffered operand by a later write.
      req_valid = 1'b1; req_src1 = 4'd4; req_src2 = 4'd9;
      step();
      req_valid = 1'b0;
      check("refresh.before", 32'(rsp_data2_n), 32'h0009);
      step();
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hA5A5;
      step();
      wr_en = 1'b0;
      check("refresh.after", 32'(rsp_data2_z), 32'hA5A5);
      rsp_ready = 1'b1;
      check("refresh.pop_data", 32'(rsp_data2_n), 32'hA5A5);
      step();
      rsp_ready = 1'b0;
      check("refresh.drained", 32'(rsp_valid_n), 32'd0);

      // Full: third request waits; one pop frees a slot for the next cycle only.
      req_valid = 1'b1; req_src1 = 4'd1; req_src2 = 4'd2;
      step();
      req_src1 = 4'd3; req_src2 = 4'd4;
      step();
      check("full.req_ready", 32'(req_ready_n), 32'd0);
      req_src1 = 4'd5; req_src2 = 4'd6;
      step();
      check("full.held", 32'(req_ready_n), 32'd0);
      check("full.head", 32'(rsp_data1_n), 32'h0011);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("full.freed", 32'(req_ready_n), 32'd1);
      step();
      req_valid = 1'b0;
      check("full.refilled", 32'(req_ready_n), 32'd0);
      rsp_ready = 1'b1;
      repeat (2) step();
      rsp_ready = 1'b0;

      // Pointer wrap: streaming push/pop pairs, in-order data checked by the model.
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_src1  = 4'(i + 1);
         req_src2  = 4'(15 - i);
         step();
      end
      req_valid = 1'b0;
      step();
      rsp_ready = 1'b0;
      check("wrap.drained", 32'(rsp_valid_n), 32'd0);

      // Simultaneous push and pop at count 1.
      wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h0001;
      step();
      wr_addr = 4'd11; wr_data = 16'h0002;
      step();
      wr_en = 1'b0;
      req_valid = 1'b1; req_src1 = 4'd10; req_src2 = 4'd10;
      step();
      check("pushpop.old_head", 32'(rsp_data1_n), 32'h0001);
      req_src1 = 4'd11; req_src2 = 4'd11; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0; rsp_ready = 1'b0;
      check("pushpop.valid", 32'(rsp_valid_n), 32'd1);
      check("pushpop.new_head", 32'(rsp_data1_n), 32'h0002);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("pushpop.one_left", 32'(rsp_valid_n), 32'd0);

      // Zero register: forced to 0 when enabled, bypassed normally when not.
      req_valid = 1'b1; req_src1 = 4'd0; req_src2 = 4'd0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      step();
      req_valid = 1'b0; wr_en = 1'b0;
      check("zero.z.rsp_data1", 32'(rsp_data1_z), 32'h0);
      check("zero.n.rsp_data1", 32'(rsp_data1_n), 32'hFFFF);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Asynchronous reset with two entries buffered.
      req_valid = 1'b1; req_src1 = 4'd1; req_src2 = 4'd2;
      step();
      req_src1 = 4'd3; req_src2 = 4'd4;
      step();
      req_valid = 1'b0;
      check("async.pre_full", 32'(req_ready_n), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      idle_state_checks("async");
      step();
      rst_n = 1'b1;
      step();
      check("async.after", 32'(rsp_valid_z), 32'd0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
